mode_cmd_rx: RTL and testbench

Host-side command receiver that writes the 16-bit mode word consumed by the DDC mode decoder, which splits it into width_mode, cal_mode and package_len. It parses a framed byte stream (sync, high byte, low byte, XOR checksum) from the host command interface, checks the frame, and commits the mode word with a one-cycle update strobe. Malformed or stalled frames are dropped and counted; the committed mode never changes on a bad frame.

---
 rtl/mode_cmd_pkg.sv | 37 +++
 rtl/mode_cmd_timeout.sv | 29 ++
 rtl/mode_cmd_rx.sv | 121 ++++++++++++
 tb/tb_mode_cmd_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mode_cmd_pkg.sv
// Shared types and constants for the host mode-command receiver.
// The mode word feeds the DDC mode decoder: width_mode, cal_mode and package_len.
`timescale 1ns/1ps
package mode_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HI     = 3'd1,
    LO     = 3'd2,
    CHK    = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam int WIDTH_MSB = 12;
  localparam int WIDTH_LSB = 11;
  localparam int CAL_MSB   = 10;
  localparam int CAL_LSB   = 8;
  localparam int PLEN_MSB  = 7;
  localparam int PLEN_LSB  = 0;
  localparam int RSVD_MSB  = 15;
  localparam int RSVD_LSB  = 13;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Reserved bits live in the high byte, so shift the word positions down by 8.
  function automatic logic frame_ok(input logic [7:0] sync_b, input logic [7:0] hi_b,
                                    input logic [7:0] lo_b, input logic [7:0] ck_b);
    return (ck_b == (sync_b ^ hi_b ^ lo_b)) &&
           (hi_b[RSVD_MSB-8:RSVD_LSB-8] == 3'b000) &&
           (lo_b[PLEN_MSB:PLEN_LSB] != 8'h00);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mode_cmd_timeout.sv
// Inter-byte stall counter; expire is high when the count has reached limit-1
// while enabled. Used by mode_cmd_rx only when MODE_CMD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module mode_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == LIMIT);

endmodule

// File: rtl/mode_cmd_rx.sv
// Framed command receiver (sync, hi, lo, xor checksum) that commits the 16-bit mode word.
// Optional inter-byte timeout enabled by defining MODE_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
module mode_cmd_rx
  import mode_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter logic [15:0] DEFAULT_MODE = 16'h0040
`ifdef MODE_CMD_TIMEOUT_EN
  , parameter int        TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] mode,
  output logic        mode_update,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output state_t      dbg_state
);

  // Handshake: a byte moves on a clk edge where cmd_valid && cmd_ready are both high;
  // cmd_ready is registered and only drops for the single COMMIT cycle.
  state_t     state;
  logic [7:0] hi_q;
  logic [7:0] lo_q;
  logic       accept;
  logic       in_frame;
  logic       expire;

  assign accept    = cmd_valid && cmd_ready;
  assign in_frame  = (state == HI) || (state == LO) || (state == CHK);
  assign dbg_state = state;

`ifdef MODE_CMD_TIMEOUT_EN
  mode_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (accept || !in_frame),
    .enable(in_frame),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      mode        <= DEFAULT_MODE;
      mode_update <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= 8'h00;
      cmd_ready   <= 1'b1;
    end else begin
      mode_update <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (cmd_data == SYNC_BYTE)) begin
            state <= HI;
          end
        end
        HI: begin
          if (accept) begin
            hi_q  <= cmd_data;
            state <= LO;
          end else if (expire) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
          end
        end
        LO: begin
          if (accept) begin
            lo_q  <= cmd_data;
            state <= CHK;
          end else if (expire) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
          end
        end
        CHK: begin
          if (accept) begin
            if (frame_ok(SYNC_BYTE, hi_q, lo_q, cmd_data)) begin
              state     <= COMMIT;
              cmd_ready <= 1'b0;
            end else begin
              state     <= IDLE;
              frame_err <= 1'b1;
              err_cnt   <= sat_inc8(err_cnt);
            end
          end else if (expire) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            err_cnt   <= sat_inc8(err_cnt);
          end
        end
        COMMIT: begin
          mode        <= {hi_q, lo_q};
          mode_update <= 1'b1;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_cmd_rx.sv
// Directed-vector bench for mode_cmd_rx: drivers push expected events into a queue,
// a negedge monitor pops and compares on every mode_update / frame_err pulse.
`timescale 1ns/1ps
module tb_mode_cmd_rx;
  import mode_cmd_pkg::*;

  localparam logic [7:0] EV_UPD = 8'h01;
  localparam logic [7:0] EV_ERR = 8'h02;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] mode;
  logic        mode_update;
  logic        frame_err;
  logic [7:0]  err_cnt;
  state_t      dbg_state;

  logic [23:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_err  = 8'h00;
  logic [15:0] exp_mode = 16'h0040;

  mode_cmd_rx dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .mode       (mode),
    .mode_update(mode_update),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  task automatic mon_pop(input string name, input logic [23:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event got %h expected none", name, act);
    end else begin
      check(name, 32'(act), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (mode_update) mon_pop("mode_update_event", {EV_UPD, mode});
        if (frame_err)   mon_pop("frame_err_event", {EV_ERR, 8'h00, err_cnt});
      end
    end
  end

  // drivers: every task starts and ends 1ns after a posedge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    cmd_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    cmd_data  = b;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: got cmd_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ck,
                            input bit good, input int max_gap);
    logic [15:0] old_mode;
    old_mode = exp_mode;
    send_byte(8'hA5, $urandom_range(0, max_gap));
    send_byte(hi, $urandom_range(0, max_gap));
    send_byte(lo, $urandom_range(0, max_gap));
    if (good) begin
      exp_mode = {hi, lo};
      exp_q.push_back({EV_UPD, exp_mode});
    end else begin
      exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      exp_q.push_back({EV_ERR, 8'h00, exp_err});
    end
    send_byte(ck, $urandom_range(0, max_gap));
    @(negedge clk);
    check("mode_held_after_ck", 32'(mode), 32'(old_mode));
    if (good) begin
      check("ready_low_commit", 32'(cmd_ready), 32'd0);
      check("state_commit", 32'(dbg_state), 32'(COMMIT));
      @(negedge clk);
      check("mode_committed", 32'(mode), 32'(exp_mode));
      check("ready_back_high", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      check("mode_update_fell", 32'(mode_update), 32'd0);
    end else begin
      check("frame_err_high", 32'(frame_err), 32'd1);
      @(negedge clk);
      check("frame_err_fell", 32'(frame_err), 32'd0);
      check("err_cnt_value", 32'(err_cnt), 32'(exp_err));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got time limit expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst       = 1'b1;
    cmd_data  = 8'h00;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mode", 32'(mode), 32'h0040);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_mode_update", 32'(mode_update), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;

    // good frame, back-to-back bytes
    send_frame(8'h0B, 8'h20, 8'h8E, 1'b1, 0);

    // bad checksum, reserved bits set, zero package_len
    send_frame(8'h0B, 8'h20, 8'h00, 1'b0, 0);
    send_frame(8'hE0, 8'h10, 8'h55, 1'b0, 0);
    send_frame(8'h01, 8'h00, 8'hA4, 1'b0, 0);
    check("mode_after_bad", 32'(mode), 32'h0B20);

    // garbage in IDLE with gaps, then good frame with gaps
    send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'hFF, $urandom_range(0, 3));
    send_byte(8'h5A, $urandom_range(0, 3));
    idle(2);
    check("garbage_err_cnt", 32'(err_cnt), 32'd3);
    send_frame(8'h09, 8'h40, 8'hEC, 1'b1, 3);
    check("garbage_mode", 32'(mode), 32'h0940);

    // stall after A5,0B
    send_byte(8'hA5, 0);
    send_byte(8'h0B, 0);
`ifdef MODE_CMD_TIMEOUT_EN
    exp_err = exp_err + 8'd1;
    exp_q.push_back({EV_ERR, 8'h00, exp_err});
    idle(1030);
    check("timeout_state", 32'(dbg_state), 32'(IDLE));
    check("timeout_err_cnt", 32'(err_cnt), 32'(exp_err));
    send_frame(8'h0B, 8'h20, 8'h8E, 1'b1, 0);
`else
    idle(1030);
    check("stall_state", 32'(dbg_state), 32'(LO));
    exp_mode = 16'h0B20;
    exp_q.push_back({EV_UPD, exp_mode});
    send_byte(8'h20, 0);
    send_byte(8'h8E, 0);
    idle(3);
    check("stall_err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
    check("stall_mode", 32'(mode), 32'h0B20);

    // reset mid-frame
    send_byte(8'hA5, 0);
    send_byte(8'h0B, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_err  = 8'h00;
    exp_mode = 16'h0040;
    @(negedge clk);
    check("midrst_mode", 32'(mode), 32'h0040);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    send_byte(8'h20, 0);
    send_byte(8'h8E, 0);
    idle(4);
    check("discard_mode", 32'(mode), 32'h0040);
    check("discard_state", 32'(dbg_state), 32'(IDLE));

    // saturation of err_cnt
    for (int i = 0; i < 260; i++) begin
      send_frame(8'h0B, 8'h20, 8'h00, 1'b0, 0);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);
    check("sat_mode", 32'(mode), 32'h0040);

    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
